// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encodings, reset cause codes,
// counter width and the registered-output decode.
package reset_sequencer_pkg;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_FILTER = 3'd1,
    SDRAM_INIT  = 3'd2,
    CAM_HOLD    = 3'd3,
    SYS_HOLD    = 3'd4,
    RUN         = 3'd5,
    SOFT_HOLD   = 3'd6
  } seq_state_t;

  localparam logic [1:0] CAUSE_POWER_ON      = 2'd0;
  localparam logic [1:0] CAUSE_LOCK_LOSS     = 2'd1;
  localparam logic [1:0] CAUSE_SOFT          = 2'd2;
  localparam logic [1:0] CAUSE_SDRAM_TIMEOUT = 2'd3;

  typedef struct packed {
    logic sdram_rst;
    logic cam_n;
    logic sys_rst;
    logic done;
  } rst_out_t;

  // Terminal count for a phase lasting `cycles` clocks with a counter starting at 0.
  function automatic logic [CNT_W-1:0] term_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

  // Reset outputs implied by a state; the camera flag only matters in SOFT_HOLD.
  function automatic rst_out_t decode_outputs(input seq_state_t s, input logic cam_flag);
    rst_out_t o;
    o.sdram_rst = (s == WAIT_LOCK) || (s == LOCK_FILTER);
    o.cam_n     = (s == CAM_HOLD) || (s == SYS_HOLD) || (s == RUN) ||
                  ((s == SOFT_HOLD) && !cam_flag);
    o.sys_rst   = (s != RUN);
    o.done      = (s == RUN);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with async active-low clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer: filters PLL lock, then releases SDRAM,
// camera and system resets in order; handles lock loss, soft resets and SDRAM timeout.
//
// state       | meaning
// WAIT_LOCK   | all resets asserted, waiting for synchronised lock
// LOCK_FILTER | counting consecutive lock-high cycles
// SDRAM_INIT  | SDRAM reset released, waiting for init done or timeout
// CAM_HOLD    | camera released, settling before system release
// SYS_HOLD    | system reset held for its minimum length
// RUN         | everything released
// SOFT_HOLD   | software-requested system (and optionally camera) reset
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES   = 16,
  parameter int SDRAM_TIMEOUT_CYCLES = 65536,
  parameter int CAM_SETTLE_CYCLES    = 4096,
  parameter int SYS_RESET_CYCLES     = 16
) (
  input  logic       systemClock,
  input  logic       nReset,
  input  logic       pllLocked,
  input  logic       softResetRequest,
  input  logic       softResetCamera,
  input  logic       sdramInitDone,
  output logic       sdramReset,
  output logic       camnReset,
  output logic       systemReset,
  output logic       sequenceDone,
  output logic [1:0] resetCause,
  output logic [2:0] sequencerState
);

  localparam logic [CNT_W-1:0] LOCK_TC  = term_count(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] SDRAM_TC = term_count(SDRAM_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CAM_TC   = term_count(CAM_SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SYS_TC   = term_count(SYS_RESET_CYCLES);

  logic             lock_sync;
  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] count;
  logic             cam_flag;
  logic             cam_flag_next;
  logic [1:0]       cause_next;
  rst_out_t         out_next;

  sync_2ff u_lock_sync (
    .clk   (systemClock),
    .rst_n (nReset),
    .d     (pllLocked),
    .q     (lock_sync)
  );

  always_comb begin
    state_next    = state;
    cause_next    = resetCause;
    cam_flag_next = cam_flag;

    // Lock loss pre-empts every other transition; a lost filter attempt is not a new cause.
    if ((state != WAIT_LOCK) && !lock_sync) begin
      state_next = WAIT_LOCK;
      if (state != LOCK_FILTER) cause_next = CAUSE_LOCK_LOSS;
    end else begin
      case (state)
        WAIT_LOCK:   if (lock_sync) state_next = LOCK_FILTER;
        LOCK_FILTER: if (count == LOCK_TC) state_next = SDRAM_INIT;
        SDRAM_INIT: begin
          if (sdramInitDone) begin
            state_next = CAM_HOLD;
          end else if (count == SDRAM_TC) begin
            state_next = WAIT_LOCK;
            cause_next = CAUSE_SDRAM_TIMEOUT;
          end
        end
        CAM_HOLD:    if (count == CAM_TC) state_next = SYS_HOLD;
        SYS_HOLD:    if (count == SYS_TC) state_next = RUN;
        RUN: begin
          if (softResetRequest) begin
            state_next    = SOFT_HOLD;
            cam_flag_next = softResetCamera;
            cause_next    = CAUSE_SOFT;
          end
        end
        SOFT_HOLD:   if (count == SYS_TC) state_next = cam_flag ? CAM_HOLD : RUN;
        default:     state_next = WAIT_LOCK;
      endcase
    end

    out_next = decode_outputs(state_next, cam_flag_next);
  end

  always_ff @(posedge systemClock or negedge nReset) begin
    if (!nReset) begin
      state        <= WAIT_LOCK;
      count        <= '0;
      cam_flag     <= 1'b0;
      resetCause   <= CAUSE_POWER_ON;
      sdramReset   <= 1'b1;
      camnReset    <= 1'b0;
      systemReset  <= 1'b1;
      sequenceDone <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= (state_next != state) ? '0 : count + CNT_W'(1);
      cam_flag     <= cam_flag_next;
      resetCause   <= cause_next;
      sdramReset   <= out_next.sdram_rst;
      camnReset    <= out_next.cam_n;
      systemReset  <= out_next.sys_rst;
      sequenceDone <= out_next.done;
    end
  end

  assign sequencerState = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed-plus-random bench for reset_sequencer; expected timings are derived from
// the sequencing rules (sync latency, phase lengths) rather than from the FSM itself.
module tb_reset_sequencer;

  localparam int LOCK_N    = 16;
  localparam int TIMEOUT_N = 256;
  localparam int CAM_N     = 32;
  localparam int SYS_N     = 16;
  localparam int SYNC_LAT  = 2;
  // Lock rise to sdramReset fall, given inputs driven just after an edge.
  localparam int RISE_TO_SDRAM = SYNC_LAT + 1 + LOCK_N;
  localparam int LOSS_LAT      = SYNC_LAT + 1;

  logic       systemClock = 1'b0;
  logic       nReset = 1'b0;
  logic       pllLocked = 1'b0;
  logic       softResetRequest = 1'b0;
  logic       softResetCamera = 1'b0;
  logic       sdramInitDone = 1'b0;
  logic       sdramReset, camnReset, systemReset, sequenceDone;
  logic [1:0] resetCause;
  logic [2:0] sequencerState;

  int n_checks = 0;
  int n_fail   = 0;
  int n, hi, lo, hi_len, lo_len, ones;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES   (LOCK_N),
    .SDRAM_TIMEOUT_CYCLES (TIMEOUT_N),
    .CAM_SETTLE_CYCLES    (CAM_N),
    .SYS_RESET_CYCLES     (SYS_N)
  ) dut (
    .systemClock      (systemClock),
    .nReset           (nReset),
    .pllLocked        (pllLocked),
    .softResetRequest (softResetRequest),
    .softResetCamera  (softResetCamera),
    .sdramInitDone    (sdramInitDone),
    .sdramReset       (sdramReset),
    .camnReset        (camnReset),
    .systemReset      (systemReset),
    .sequenceDone     (sequenceDone),
    .resetCause       (resetCause),
    .sequencerState   (sequencerState)
  );

  always #5 systemClock = ~systemClock;

  task automatic step();
    @(posedge systemClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic sd, input logic cn, input logic sy,
                         input logic dn, input logic [1:0] cause, input logic [2:0] st);
    chk({tag, "_sdramReset"}, sdramReset, sd);
    chk({tag, "_camnReset"}, camnReset, cn);
    chk({tag, "_systemReset"}, systemReset, sy);
    chk({tag, "_sequenceDone"}, sequenceDone, dn);
    chk({tag, "_resetCause"}, resetCause, cause);
    chk({tag, "_state"}, sequencerState, st);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sdramReset;
      1:       return camnReset;
      2:       return systemReset;
      3:       return sequenceDone;
      default: return 1'bx;
    endcase
  endfunction

  // Steps until the selected output reaches val; returns limit+1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int limit, output int cnt);
    cnt = 0;
    while (cnt <= limit) begin
      step();
      cnt++;
      if (sig(sel) === val) break;
    end
  endtask

  // One-cycle soft request from RUN; optionally a second request at step extra_at that must be ignored.
  task automatic soft_reset(input logic cam, input int extra_at,
                            output int cnt, output int sys_hi, output int cam_lo);
    softResetCamera  = cam;
    softResetRequest = 1'b1;
    step();
    softResetRequest = 1'b0;
    softResetCamera  = 1'b0;
    cnt    = 1;
    sys_hi = int'(systemReset);
    cam_lo = int'(!camnReset);
    chk("soft_cause", resetCause, 2);
    while (!sequenceDone && cnt < 200) begin
      if (cnt == extra_at) begin
        softResetRequest = 1'b1;
        softResetCamera  = ~cam;
      end
      step();
      softResetRequest = 1'b0;
      cnt++;
      sys_hi += int'(systemReset);
      cam_lo += int'(!camnReset);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk_all("reset", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
    nReset = 1'b1;
    repeat ($urandom_range(1, 5)) step();
    chk("idle_no_lock_state", sequencerState, 0);

    // Power-on sequence
    pllLocked = 1'b1;
    wait_sig(0, 1'b0, 40, n);
    chk("por_sdram_fall_window", (n >= RISE_TO_SDRAM - 1) && (n <= RISE_TO_SDRAM), 1);
    chk("por_state_sdram_init", sequencerState, 2);
    repeat (100) step();
    chk("por_camn_before_done", camnReset, 0);
    sdramInitDone = 1'b1;
    step();
    chk("por_camn_rise", camnReset, 1);
    wait_sig(2, 1'b0, 100, n);
    chk("por_sys_fall_latency", n, CAM_N + SYS_N);
    chk_all("por_run", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd5);

    // Soft reset without camera, stray request during the hold
    repeat ($urandom_range(1, 10)) step();
    soft_reset(1'b0, $urandom_range(3, 10), n, hi, lo);
    chk("soft0_total", n, SYS_N + 1);
    chk("soft0_sys_high", hi, SYS_N);
    chk("soft0_cam_low", lo, 0);
    chk_all("soft0_run", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5);

    // Soft reset with camera
    repeat ($urandom_range(1, 10)) step();
    soft_reset(1'b1, $urandom_range(3, 10), n, hi, lo);
    chk("soft1_total", n, SYS_N + CAM_N + SYS_N + 1);
    chk("soft1_sys_high", hi, SYS_N + CAM_N + SYS_N);
    chk("soft1_cam_low", lo, SYS_N);

    // Lock loss in RUN with a coincident soft request
    pllLocked = 1'b0;
    repeat (LOSS_LAT - 1) step();
    chk("loss_run_still_done", sequenceDone, 1);
    softResetRequest = 1'b1;
    softResetCamera  = 1'($urandom_range(0, 1));
    step();
    softResetRequest = 1'b0;
    chk_all("loss_run", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0);
    step();
    chk("loss_run_no_queue_state", sequencerState, 0);

    // Re-lock with sdramInitDone already high
    repeat ($urandom_range(1, 6)) step();
    pllLocked = 1'b1;
    wait_sig(3, 1'b1, 300, n);
    chk("relock_run_window", (n >= RISE_TO_SDRAM + CAM_N + SYS_N) &&
                             (n <= RISE_TO_SDRAM + 1 + CAM_N + SYS_N), 1);
    chk("relock_cause_held", resetCause, 1);

    // Lock loss during SOFT_HOLD
    softResetCamera  = 1'b1;
    softResetRequest = 1'b1;
    step();
    softResetRequest = 1'b0;
    chk("softhold_state", sequencerState, 6);
    chk("softhold_sdram_released", sdramReset, 0);
    chk("softhold_camn", camnReset, 0);
    repeat ($urandom_range(1, 8)) step();
    pllLocked = 1'b0;
    repeat (LOSS_LAT) step();
    chk_all("loss_softhold", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd0);

    // Lock glitch shorter than the filter
    sdramInitDone = 1'b0;
    step();
    hi_len = $urandom_range(5, 12);
    lo_len = $urandom_range(3, 5);
    ones = 0;
    pllLocked = 1'b1;
    repeat (hi_len) begin step(); ones += int'(sdramReset); end
    chk("glitch_in_filter", sequencerState, 1);
    pllLocked = 1'b0;
    repeat (lo_len) begin step(); ones += int'(sdramReset); end
    chk("glitch_sdram_held", ones, hi_len + lo_len);
    chk("glitch_back_to_wait", sequencerState, 0);
    chk("glitch_cause_unchanged", resetCause, 1);
    pllLocked = 1'b1;
    wait_sig(0, 1'b0, 60, n);
    chk("glitch_filter_restart", (n >= RISE_TO_SDRAM - 1) && (n <= RISE_TO_SDRAM), 1);

    // SDRAM init timeout
    wait_sig(0, 1'b1, TIMEOUT_N + 20, n);
    chk("timeout_len", n, TIMEOUT_N);
    chk_all("timeout", 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 3'd0);
    wait_sig(0, 1'b0, 40, n);
    chk("retry_sdram_fall", n, 1 + LOCK_N);

    // Retry: init done lands on the timeout cycle and must win
    repeat (TIMEOUT_N - 1) step();
    sdramInitDone = 1'b1;
    step();
    chk("tie_camn", camnReset, 1);
    chk("tie_state", sequencerState, 3);
    chk("tie_sdram", sdramReset, 0);
    wait_sig(3, 1'b1, 100, n);
    chk("retry_run_latency", n, CAM_N + SYS_N);
    chk("retry_cause", resetCause, 3);

    // Async reset in CAM_HOLD (reached via camera soft reset)
    softResetCamera  = 1'b1;
    softResetRequest = 1'b1;
    step();
    softResetRequest = 1'b0;
    repeat (SYS_N) step();
    repeat ($urandom_range(1, 20)) step();
    chk("pre_async_state", sequencerState, 3);
    nReset = 1'b0;
    #2;
    chk_all("async_reset", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
    step();
    nReset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
